quad_step_gen: RTL and testbench



---
 rtl/quad_step_gen.sv | 190 +++++++++++++++++++
 tb/tb_quad_step_gen.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_step_gen.sv
// Quadrature step generator: turns add/sub step requests into detent-style
// A/B waveforms, buffering bursts in a saturating signed pending counter.
module quad_step_gen #(
    parameter int PHASE_CYCLES = 4,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             add,
    input  logic             sub,
    output logic             A,
    output logic             B,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             ovf
);

    localparam int PH_W  = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam int SUM_W = CNT_W + 2;
    localparam int MAXV  = (2 ** (CNT_W - 1)) - 1;

    localparam logic [PH_W-1:0]         PH_LAST = PH_W'(PHASE_CYCLES - 1);
    localparam logic signed [SUM_W-1:0] LIM_POS = SUM_W'(MAXV);
    localparam logic signed [SUM_W-1:0] LIM_NEG = -SUM_W'(MAXV);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH1  = 3'd1,
        PH2  = 3'd2,
        PH3  = 3'd3,
        PH4  = 3'd4
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [PH_W-1:0]           r_phase_cnt;
    logic [PH_W-1:0]           w_phase_cnt_next;
    logic                      r_dir;          // 1 = add, 0 = sub
    logic                      w_dir_next;
    logic signed [CNT_W-1:0]   r_pending;
    logic signed [CNT_W-1:0]   w_pending_next;
    logic                      r_ovf;
    logic                      w_ovf_next;
    logic                      r_a;
    logic                      r_b;
    logic                      w_a_next;
    logic                      w_b_next;

    logic                      w_phase_done;
    logic                      w_pend_nz;
    logic                      w_pend_pos;
    logic                      w_start;
    logic signed [SUM_W-1:0]   w_pend_ext;
    logic signed [SUM_W-1:0]   w_req;
    logic signed [SUM_W-1:0]   w_cons;
    logic signed [SUM_W-1:0]   w_sum;
    logic signed [SUM_W-1:0]   w_kept;

    assign w_phase_done = (r_phase_cnt == PH_LAST);
    assign w_pend_nz    = (r_pending != '0);
    assign w_pend_pos   = w_pend_nz && !r_pending[CNT_W-1];
    assign w_pend_ext   = {{2{r_pending[CNT_W-1]}}, r_pending};

    // Next-state logic for the phase sequencer.
    always_comb begin
        w_state_next     = r_state;
        w_phase_cnt_next = r_phase_cnt;
        w_dir_next       = r_dir;
        w_start          = 1'b0;

        case (r_state)
            IDLE: begin
                w_phase_cnt_next = '0;
                if (w_pend_nz) begin
                    w_start = 1'b1;
                end
            end
            PH1, PH2, PH3: begin
                if (w_phase_done) begin
                    w_phase_cnt_next = '0;
                    case (r_state)
                        PH1:     w_state_next = PH2;
                        PH2:     w_state_next = PH3;
                        default: w_state_next = PH4;
                    endcase
                end else begin
                    w_phase_cnt_next = r_phase_cnt + 1'b1;
                end
            end
            PH4: begin
                if (w_phase_done) begin
                    w_phase_cnt_next = '0;
                    if (w_pend_nz) begin
                        w_start = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_phase_cnt_next = r_phase_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next     = IDLE;
                w_phase_cnt_next = '0;
            end
        endcase

        if (w_start) begin
            w_state_next     = PH1;
            w_phase_cnt_next = '0;
            w_dir_next       = w_pend_pos;
        end
    end

    // Pending queue: a request that would overshoot a limit is dropped, but
    // the consume of a starting step still applies.
    always_comb begin
        w_req = '0;
        if (add && !sub) begin
            w_req = SUM_W'(1);
        end else if (sub && !add) begin
            w_req = -SUM_W'(1);
        end

        w_cons = '0;
        if (w_start) begin
            w_cons = w_pend_pos ? SUM_W'(1) : -SUM_W'(1);
        end

        w_kept     = w_pend_ext - w_cons;
        w_sum      = w_kept + w_req;
        w_ovf_next = 1'b0;
        w_pending_next = w_sum[CNT_W-1:0];
        if ((w_sum > LIM_POS) || (w_sum < LIM_NEG)) begin
            w_ovf_next     = 1'b1;
            w_pending_next = w_kept[CNT_W-1:0];
        end
    end

    // A/B follow the state being entered so the outputs stay registered.
    always_comb begin
        w_a_next = 1'b1;
        w_b_next = 1'b1;
        case (w_state_next)
            PH1: begin
                w_a_next = w_dir_next;
                w_b_next = !w_dir_next;
            end
            PH2: begin
                w_a_next = 1'b0;
                w_b_next = 1'b0;
            end
            PH3: begin
                w_a_next = !w_dir_next;
                w_b_next = w_dir_next;
            end
            default: begin
                w_a_next = 1'b1;
                w_b_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_phase_cnt <= '0;
            r_dir       <= 1'b1;
            r_pending   <= '0;
            r_ovf       <= 1'b0;
            r_a         <= 1'b1;
            r_b         <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_phase_cnt <= w_phase_cnt_next;
            r_dir       <= w_dir_next;
            r_pending   <= w_pending_next;
            r_ovf       <= w_ovf_next;
            r_a         <= w_a_next;
            r_b         <= w_b_next;
        end
    end

    assign A       = r_a;
    assign B       = r_b;
    assign busy    = (r_state != IDLE);
    assign pending = r_pending;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_quad_step_gen.sv
// Directed bench for quad_step_gen with a small quadrature decoder model that
// counts complete add/sub detents on the A/B outputs.
module tb_quad_step_gen;

    localparam int PC = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          add;
    logic          sub;
    logic          A;
    logic          B;
    logic          busy;
    logic [CW-1:0] pending;
    logic          ovf;

    int n_checks = 0;
    int n_fail   = 0;

    int         dec_adds = 0;
    int         dec_subs = 0;
    int         dec_acc  = 0;
    logic [1:0] dec_prev = 2'b11;

    always #5 clk = ~clk;

    quad_step_gen #(
        .PHASE_CYCLES(PC),
        .CNT_W       (CW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .add    (add),
        .sub    (sub),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .pending(pending),
        .ovf    (ovf)
    );

    // Position along the add rotation 11 -> 10 -> 00 -> 01 -> 11.
    function automatic int ab_pos(input logic [1:0] ab);
        case (ab)
            2'b11:   return 0;
            2'b10:   return 1;
            2'b00:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int dec_step(input logic [1:0] prv, input logic [1:0] cur);
        int d;
        d = (ab_pos(cur) - ab_pos(prv) + 4) % 4;
        if (d == 1) return 1;
        if (d == 3) return -1;
        return 0;
    endfunction

    // Decoder model: one event per full detent, reported on return to 11.
    always @(negedge clk) begin
        if ({A, B} != dec_prev) begin
            if ({A, B} == 2'b11) begin
                if (dec_acc + dec_step(dec_prev, {A, B}) == 4)
                    dec_adds <= dec_adds + 1;
                else if (dec_acc + dec_step(dec_prev, {A, B}) == -4)
                    dec_subs <= dec_subs + 1;
                dec_acc <= 0;
            end else begin
                dec_acc <= dec_acc + dec_step(dec_prev, {A, B});
            end
        end
        dec_prev <= {A, B};
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pend();
        return int'($signed(pending));
    endfunction

    function automatic int ab();
        return int'({A, B});
    endfunction

    task automatic wait_idle(input int max_cycles);
        for (int k = 0; k < max_cycles; k++) begin
            if (!busy) break;
            tick();
        end
        check("idle_timeout", int'(busy), 0);
    endtask

    task automatic single_step(input bit is_add);
        int a0, s0, nbusy, exp_ab;
        int seq [4];
        if (is_add) seq = '{2, 0, 1, 3};
        else        seq = '{1, 0, 2, 3};
        a0 = dec_adds;
        s0 = dec_subs;
        add = is_add;
        sub = !is_add;
        tick();
        add = 1'b0;
        sub = 1'b0;
        check("req_pending", pend(), is_add ? 1 : -1);
        check("req_ab_idle", ab(), 3);
        check("req_busy", int'(busy), 0);
        nbusy = 0;
        for (int k = 0; k < 4 * PC; k++) begin
            tick();
            exp_ab = seq[k / PC];
            check(is_add ? "add_ab" : "sub_ab", ab(), exp_ab);
            nbusy += int'(busy);
        end
        check("step_pending", pend(), 0);
        tick();
        check("end_ab", ab(), 3);
        check("end_busy", int'(busy), 0);
        check("busy_cycles", nbusy, 4 * PC);
        check("dec_adds", dec_adds - a0, is_add ? 1 : 0);
        check("dec_subs", dec_subs - s0, is_add ? 0 : 1);
        $display("single %s step done", is_add ? "add" : "sub");
    endtask

    initial begin
        int a0, s0, nbusy, novf;
        rst = 1'b1;
        add = 1'b0;
        sub = 1'b0;
        tick();
        tick();
        check("rst_A", int'(A), 1);
        check("rst_B", int'(B), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_pending", pend(), 0);
        rst = 1'b0;
        tick();
        $display("reset done");

        single_step(1'b1);
        tick();
        single_step(1'b0);
        tick();

        // Back-to-back adds on three consecutive cycles.
        a0 = dec_adds;
        nbusy = 0;
        add = 1'b1;
        tick();
        check("b2b_p1", pend(), 1);
        tick();
        check("b2b_p2", pend(), 1);
        nbusy += int'(busy);
        tick();
        add = 1'b0;
        check("b2b_p3", pend(), 2);
        nbusy += int'(busy);
        for (int e = 4; e <= 55; e++) begin
            tick();
            if (e == 17) check("b2b_pre_start2", pend(), 2);
            if (e == 18) check("b2b_start2", pend(), 1);
            if (e == 34) check("b2b_start3", pend(), 0);
            if (e == 50) check("b2b_idle", int'(busy), 0);
            nbusy += int'(busy);
        end
        check("b2b_busy_cycles", nbusy, 12 * PC);
        check("b2b_dec_adds", dec_adds - a0, 3);
        $display("back-to-back adds done");

        // Simultaneous add and sub cancel.
        add = 1'b1;
        sub = 1'b1;
        tick();
        add = 1'b0;
        sub = 1'b0;
        check("cancel_pending", pend(), 0);
        check("cancel_ovf", int'(ovf), 0);
        check("cancel_busy", int'(busy), 0);
        check("cancel_ab", ab(), 3);
        tick();
        check("cancel_busy2", int'(busy), 0);
        $display("cancel done");

        // Saturation: ten consecutive add cycles.
        a0 = dec_adds;
        novf = 0;
        add = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            novf += int'(ovf);
            if (i == 8) begin
                check("ovf_p8", pend(), 7);
                check("ovf_o8", int'(ovf), 0);
            end
            if (i >= 9) begin
                check("ovf_pulse", int'(ovf), 1);
                check("ovf_hold", pend(), 7);
            end
        end
        add = 1'b0;
        tick();
        check("ovf_clear", int'(ovf), 0);
        check("ovf_count", novf, 2);
        wait_idle(400);
        check("ovf_dec_adds", dec_adds - a0, 8);
        $display("overflow done");

        // Reversal mid-step: opposite request only trims the queue.
        a0 = dec_adds;
        s0 = dec_subs;
        add = 1'b1;
        tick();
        tick();
        tick();
        add = 1'b0;
        check("rev_pending", pend(), 2);
        tick();
        sub = 1'b1;
        tick();
        sub = 1'b0;
        check("rev_after_sub", pend(), 1);
        check("rev_busy", int'(busy), 1);
        wait_idle(200);
        check("rev_dec_adds", dec_adds - a0, 2);
        check("rev_dec_subs", dec_subs - s0, 0);
        $display("reversal done");

        // Reset during PH2 with a step still queued.
        tick();
        a0 = dec_adds;
        s0 = dec_subs;
        add = 1'b1;
        tick();
        add = 1'b0;
        tick();
        add = 1'b1;
        tick();
        add = 1'b0;
        check("rst_mid_queued", pend(), 1);
        tick();
        tick();
        tick();
        check("rst_mid_ph2", ab(), 0);
        rst = 1'b1;
        tick();
        check("rst_mid_ab", ab(), 3);
        check("rst_mid_pending", pend(), 0);
        check("rst_mid_busy", int'(busy), 0);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) tick();
        check("rst_mid_idle", int'(busy), 0);
        check("rst_mid_dec_adds", dec_adds - a0, 0);
        check("rst_mid_dec_subs", dec_subs - s0, 0);
        $display("mid-step reset done");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
